// File: rtl/calc_datapath.sv
// calc_datapath: register file, input mux, ALU and output stage of the small
// calculator. It executes one control word per cycle from the control unit.
// All state clears asynchronously while rst is low.
module calc_datapath #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       s1,
  input  logic [1:0]       WA,
  input  logic             WE,
  input  logic [1:0]       RAA,
  input  logic [1:0]       RAB,
  input  logic             REA,
  input  logic             REB,
  input  logic [1:0]       C,
  input  logic             S2,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             valid
);

  // Operation and mux select encodings
  localparam logic [1:0] OP_ADD = 2'd3;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd0;

  localparam logic [1:0] SEL_IN1  = 2'd3;
  localparam logic [1:0] SEL_IN2  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd1;
  localparam logic [1:0] SEL_ALU  = 2'd0;

  // Four ordinary register-file entries; rf[0] is writable like the rest
  logic [3:0][WIDTH-1:0] rf;

  // Operand latches feeding the ALU
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // ALU outputs
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH:0]   alu_diff;

  // Register-file write data from MUX1
  logic [WIDTH-1:0] wr_data;

  // Extended-width add/sub so the carry/borrow bit comes out naturally
  assign alu_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign alu_diff = {1'b0, a_q} - {1'b0, b_q};

  // ALU: operate on the latched operands, result truncated to WIDTH bits
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (C)
      OP_ADD: begin
        alu_result = alu_sum[WIDTH-1:0];
        alu_carry  = alu_sum[WIDTH];
      end
      OP_SUB: begin
        alu_result = alu_diff[WIDTH-1:0];
        // Unsigned borrow: set exactly when a_q < b_q
        alu_carry  = alu_diff[WIDTH];
      end
      OP_AND: begin
        alu_result = a_q & b_q;
        alu_carry  = 1'b0;
      end
      OP_XOR: begin
        alu_result = a_q ^ b_q;
        alu_carry  = 1'b0;
      end
      default: begin
        alu_result = '0;
        alu_carry  = 1'b0;
      end
    endcase
  end

  // MUX1: choose the register-file write data
  always_comb begin
    wr_data = '0;
    case (s1)
      SEL_IN1:  wr_data = in1;
      SEL_IN2:  wr_data = in2;
      SEL_ZERO: wr_data = '0;
      SEL_ALU:  wr_data = alu_result;
      default:  wr_data = '0;
    endcase
  end

  // Register file write; reads elsewhere see pre-write contents on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf <= '0;
    end else if (WE) begin
      rf[WA] <= wr_data;
    end
  end

  // Operand latches load independently from the two read ports, no bypass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (REA) a_q <= rf[RAA];
      if (REB) b_q <= rf[RAB];
    end
  end

  // Carry flag follows the ALU only when an ALU result is being stored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cout <= 1'b0;
    end else if (WE && (s1 == SEL_ALU)) begin
      cout <= alu_carry;
    end
  end

  // Output stage: S2 copies the (pre-write) result register and pulses valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= S2;
      if (S2) out <= rf[3];
    end
  end

endmodule

// File: tb/tb_calc_datapath.sv
// Bench for calc_datapath: a driver issues control words and a reference
// model pushes expected results into a scoreboard queue; a separate monitor
// pops and compares whenever valid is presented.
module tb_calc_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in1, in2;
  logic [1:0] s1, WA, RAA, RAB, C;
  logic       WE, REA, REB, S2;
  logic [3:0] out;
  logic       cout, valid;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int rf_m [4];
  int a_m, b_m, cout_m;

  typedef struct packed {
    logic [3:0] o;
    logic       c;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   last_out;

  always #5 clk = ~clk;

  calc_datapath #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .s1(s1), .WA(WA), .WE(WE),
    .RAA(RAA), .RAB(RAB), .REA(REA), .REB(REB), .C(C), .S2(S2),
    .out(out), .cout(cout), .valid(valid)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rf_m[i] = 0;
    a_m = 0; b_m = 0; cout_m = 0;
  endtask

  // Apply the calculator rules for one clock edge using plain arithmetic
  task automatic model_step();
    int a, b, res, car, wd, ncout, na, nb;
    a = a_m; b = b_m; res = 0; car = 0;
    case (int'(C))
      3: begin res = (a + b) % 16; car = ((a + b) > 15) ? 1 : 0; end
      2: begin res = (a - b + 16) % 16; car = (a < b) ? 1 : 0; end
      1: begin res = a & b; car = 0; end
      default: begin res = a ^ b; car = 0; end
    endcase
    case (int'(s1))
      3: wd = int'(in1);
      2: wd = int'(in2);
      1: wd = 0;
      default: wd = res;
    endcase
    ncout = (WE && s1 == 2'd0) ? car : cout_m;
    if (S2) sb.push_back(exp_t'{o: 4'(rf_m[3]), c: ncout[0]});
    na = REA ? rf_m[int'(RAA)] : a_m;
    nb = REB ? rf_m[int'(RAB)] : b_m;
    if (WE) rf_m[int'(WA)] = wd;
    a_m = na; b_m = nb; cout_m = ncout;
  endtask

  // One control word for one cycle; inputs change 2 time units after the edge
  task automatic cycle(input logic [1:0] ts1, input logic [1:0] twa, input logic twe,
                       input logic [1:0] traa, input logic [1:0] trab,
                       input logic trea, input logic treb,
                       input logic [1:0] tc, input logic ts2);
    s1 = ts1; WA = twa; WE = twe; RAA = traa; RAB = trab;
    REA = trea; REB = treb; C = tc; S2 = ts2;
    @(posedge clk);
    if (rst) model_step();
    #2;
  endtask

  task automatic idle();
    cycle(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // Standard five-state sequence: WRITE1, WRITE2, READ, ALU, OUTPUT
  task automatic op(input logic [3:0] i1, input logic [3:0] i2, input logic [1:0] c);
    in1 = i1; in2 = i2;
    cycle(2'd3, 2'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle(2'd2, 2'd2, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b0, 2'd1, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0);
    cycle(2'd0, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, c, 1'b0);
    cycle(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
  endtask

  // Directed operation with hand-computed expected values
  task automatic dop(input string name, input logic [3:0] i1, input logic [3:0] i2,
                     input logic [1:0] c, input int eo, input int ec);
    op(i1, i2, c);
    check({name, "_out"}, int'(out), eo);
    check({name, "_cout"}, int'(cout), ec);
    check({name, "_valid_hi"}, int'(valid), 1);
    idle();
    check({name, "_valid_lo"}, int'(valid), 0);
    check({name, "_out_hold"}, int'(out), eo);
  endtask

  // Monitor: every valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst) begin
      last_out = 0;
    end else if (valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_out", int'(out), int'(mon_e.o));
        check("sb_cout", int'(cout), int'(mon_e.c));
      end
      last_out = int'(out);
    end else begin
      check("out_hold", int'(out), last_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in1 = '0; in2 = '0;
    s1 = '0; WA = '0; WE = 1'b0; RAA = '0; RAB = '0; REA = 1'b0; REB = 1'b0; C = '0; S2 = 1'b0;
    model_reset();
    #12;
    check("reset_out", int'(out), 0);
    check("reset_cout", int'(cout), 0);
    check("reset_valid", int'(valid), 0);
    #5 rst = 1'b1;

    // Directed operations from the test plan
    dop("add", 4'd5, 4'd3, 2'd3, 8, 0);
    dop("sub_under", 4'd3, 4'd5, 2'd2, 14, 1);
    dop("sub", 4'd9, 4'd4, 2'd2, 5, 0);
    dop("add_ovf", 4'd9, 4'd8, 2'd3, 1, 1);
    dop("and", 4'hC, 4'hA, 2'd1, 8, 0);
    dop("xor", 4'hC, 4'hA, 2'd0, 6, 0);

    // Same-edge write and read of rf[1]: latch must see the old value 2
    in1 = 4'd2;
    cycle(2'd3, 2'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle(2'd1, 2'd2, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    in1 = 4'd7;
    cycle(2'd3, 2'd1, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0);
    cycle(2'd0, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b0);
    cycle(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("hazard_old_a", int'(out), 2);
    cycle(2'd0, 2'd0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    cycle(2'd0, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b0);
    cycle(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("hazard_new_a", int'(out), 7);
    // Same-edge S2 and write to rf[3]: out gets the old rf[3]
    in2 = 4'd9;
    cycle(2'd2, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("s2_write_old", int'(out), 7);
    cycle(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("s2_consec_new", int'(out), 9);
    check("s2_consec_valid", int'(valid), 1);
    idle();

    // Reset mid-operation, dropped off-edge between READ and ALU
    in1 = 4'd5; in2 = 4'd3;
    cycle(2'd3, 2'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle(2'd2, 2'd2, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b0, 2'd1, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("midrst_out", int'(out), 0);
    check("midrst_cout", int'(cout), 0);
    check("midrst_valid", int'(valid), 0);
    model_reset();
    in1 = 4'hF; in2 = 4'hF;
    cycle(2'd3, 2'd1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 2'd3, 1'b1);
    cycle(2'd2, 2'd3, 1'b1, 2'd3, 2'd2, 1'b1, 1'b1, 2'd3, 1'b1);
    rst = 1'b1;
    // Latches and rf[1]+rf[2] must all still be zero
    cycle(2'd0, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b0);
    cycle(2'd0, 2'd0, 1'b0, 2'd1, 2'd2, 1'b1, 1'b1, 2'd0, 1'b1);
    check("postrst_latches", int'(out), 0);
    cycle(2'd0, 2'd3, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b0);
    cycle(2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("postrst_rf", int'(out), 0);
    idle();
    dop("postrst_add", 4'd5, 4'd3, 2'd3, 8, 0);

    // Randomized back-to-back standard sequences
    for (int n = 0; n < 40; n++) begin
      op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    end

    // Fully random control words: hazards, consecutive S2, arbitrary reads
    for (int n = 0; n < 300; n++) begin
      in1 = 4'($urandom_range(0, 15));
      in2 = 4'($urandom_range(0, 15));
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    idle();
    idle();
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
